ysyx_041461_booth_mul_seq: RTL and testbench
============================================

Name: ysyx_041461_booth_mul_seq

Overview:
Iterative radix-4 Booth multiplier sequencer for the EXU's M-extension path: mul, mulh, mulhsu, mulhu and mulw.
- Accepts one operation through a valid/ready handshake.
- Drives the shared Booth partial-product generator for one radix-4 step per cycle and accumulates the 128-bit product.
- Presents the result through a second valid/ready handshake to the writeback mux.
- Supports pipeline flush.

Parameters:
XLEN, 64, operand width; full product is 2*XLEN bits.
STEPS, XLEN/2+1, radix-4 iterations for a full-width op (33).
STEPS_W, XLEN/4+1, radix-4 iterations for a word op (17).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mul_valid  in  1  request valid
mul_ready  out  1  sequencer can accept a request
mulw  in  1  1 = 32-bit word op
mul_signed  in  2  [1] multiplicand signed, [0] multiplier signed; 11 mulh/mul, 10 mulhsu, 00 mulhu
multiplicand  in  64  operand A
multiplier  in  64  operand B
flush  in  1  kill the in-flight op
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result_hi  out  64  product[127:64]
result_lo  out  64  product[63:0]; for mulw, sign-extended product[31:0]

Behaviour:
- Reset:
  - state = IDLE.
  - acc, x_reg, y_reg, cnt and all outputs = 0.
  - mul_ready = 0 while rst is high.
- States:
  - IDLE: mul_ready = ~flush.
  - BUSY: mul_ready = 0, out_valid = 0.
  - DONE: out_valid = 1, mul_ready = 0.
- Accept in IDLE (mul_valid & mul_ready), then go to BUSY:
  - x_reg (128) = multiplicand sign-extended if mul_signed[1], else zero-extended. For mulw, extension is from bit 31.
  - y_reg = {ext, ext, multiplier, 1'b0}. ext is multiplier[63] if mul_signed[0], else 0. For mulw, use {ext, ext, multiplier[31:0], 1'b0} with ext from bit 31.
  - acc = 0; cnt = 0.
- BUSY step, once per cycle:
  - src = y_reg[2:0]; the Booth generator returns p (128) and c.
  - acc <= acc + p + c, modulo 2^128.
  - x_reg <= x_reg << 2; y_reg <= y_reg >> 2.
  - cnt++.
  - After the step with cnt == N-1 (N = STEPS, or STEPS_W when mulw), go to DONE.
- Booth encoding required of the generator:
  - 000 / 111 → 0
  - 001 / 010 → +x
  - 011 → +2x
  - 100 → −2x (~(x<<1), c=1)
  - 101 / 110 → −x (~x, c=1)
- Latency: out_valid rises N+1 cycles after the accept edge (34 for full-width, 18 for mulw).
- DONE:
  - result_hi / result_lo are driven from acc and held stable until out_valid & out_ready.
  - On that handshake, go to IDLE. A new request is accepted no earlier than the following cycle (no same-cycle turnaround).
- mulw: result_lo = {{32{acc[31]}}, acc[31:0]}; result_hi = acc[127:64] (don't-care to consumer).
- Flush priority, highest first: rst, flush, normal transitions.
  - flush in BUSY or DONE: IDLE next cycle, out_valid = 0 next cycle, acc content discarded.
  - flush in IDLE: the request is not accepted.
- mul_valid while not in IDLE is ignored; operands are sampled only at accept.
- Outputs are registered; no combinational path from operands to outputs. mul_ready and out_valid depend only on state and flush.

Decomposition:
- Shared package ysyx_041461_mul_pkg holds:
  - state encoding (IDLE, BUSY, DONE)
  - XLEN, STEPS, STEPS_W
  - mul_signed codes (MUL_SS = 2'b11, MUL_SU = 2'b10, MUL_UU = 2'b00)
- Sub-module: one instance of the existing ysyx_041461_Booth_core (src 3 bits, x 128 bits → p 128 bits, c 1 bit). The sequencer relies on the full encoding above, including the +2x case.

Test Plan:
- Signed×signed 3 × −5, held full-width → out_valid exactly 34 cycles after accept; result_hi = 0xFFFF_FFFF_FFFF_FFFF, result_lo = 0xFFFF_FFFF_FFFF_FFF1.
- Signed 7 × 6 (exercises −2x then +2x) → result_lo = 42, result_hi = 0. Unsigned 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → hi = 0xFFFF_FFFF_FFFF_FFFE, lo = 1.
- mulhsu: −1 × 0xFFFF_FFFF_FFFF_FFFF (mul_signed = 10) → hi = 0xFFFF_FFFF_FFFF_FFFF, lo = 0x0000_0000_0000_0001.
- mulw 0x7FFF_FFFF × 2 → out_valid at 18 cycles; result_lo = 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: out_ready low 5 cycles after out_valid → out_valid and results stable, mul_ready = 0. After the handshake, the next request is accepted the following cycle and completes correctly.
- Flush asserted in BUSY cycle 10 (also repeat with rst) → IDLE next cycle, out_valid never rises for the killed op. Flush concurrent with mul_valid in IDLE → not accepted. A following 5 × 5 request → lo = 25.

Source files
------------

// File: rtl/ysyx_041461_booth_mul_seq_pkg.sv
// Shared types and constants for the radix-4 Booth multiply sequencer.
package ysyx_041461_mul_pkg;

  localparam int XLEN    = 64;
  localparam int PW      = 2 * XLEN;      // full product width
  localparam int STEPS   = XLEN / 2 + 1;  // radix-4 steps, full-width op
  localparam int STEPS_W = XLEN / 4 + 1;  // radix-4 steps, word op
  localparam int YW      = XLEN + 3;      // {ext, ext, multiplier, 1'b0}
  localparam int CNT_W   = $clog2(STEPS + 1);

  // mul_signed: [1] multiplicand signed, [0] multiplier signed
  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Widen the multiplicand to the product width; word ops extend from bit 31.
  function automatic logic [PW-1:0] ext_x(input logic [XLEN-1:0] a,
                                          input logic sgn, input logic w);
    logic ext;
    if (w) begin
      ext    = sgn & a[31];
      ext_x  = {{(PW-32){ext}}, a[31:0]};
    end else begin
      ext    = sgn & a[XLEN-1];
      ext_x  = {{(PW-XLEN){ext}}, a};
    end
  endfunction

  // Booth-scan form of the multiplier: two extension bits on top and an
  // implicit zero below bit 0. Word ops keep extending above bit 31 so the
  // unused upper scan windows stay harmless.
  function automatic logic [YW-1:0] ext_y(input logic [XLEN-1:0] b,
                                          input logic sgn, input logic w);
    logic ext;
    if (w) begin
      ext   = sgn & b[31];
      ext_y = {{(YW-33){ext}}, b[31:0], 1'b0};
    end else begin
      ext   = sgn & b[XLEN-1];
      ext_y = {ext, ext, b, 1'b0};
    end
  endfunction

endpackage

// File: rtl/ysyx_041461_booth_mul_seq_if.sv
// Request / result handshake bundle between the EXU and the multiply sequencer.
interface ysyx_041461_booth_mul_seq_if;
  import ysyx_041461_mul_pkg::*;

  logic              mul_valid;
  logic              mul_ready;
  logic              mulw;
  logic [1:0]        mul_signed;
  logic [XLEN-1:0]   multiplicand;
  logic [XLEN-1:0]   multiplier;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result_hi;
  logic [XLEN-1:0]   result_lo;

  // Issuer / consumer side
  modport master (
    output mul_valid, mulw, mul_signed, multiplicand, multiplier, flush, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  // Sequencer side
  modport slave (
    input  mul_valid, mulw, mul_signed, multiplicand, multiplier, flush, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_041461_booth_mul_seq_booth.sv
// Radix-4 Booth partial-product generator: selects 0, +-x or +-2x from a
// 3-bit scan window. Negation is one's complement plus carry-in c.
module ysyx_041461_Booth_core
  import ysyx_041461_mul_pkg::*;
(
  input  logic [2:0]    i_src,
  input  logic [PW-1:0] i_x,
  output logic [PW-1:0] o_p,
  output logic          o_c
);

  // Decode the Booth window into a partial product
  always_comb begin
    o_p = '0;
    o_c = 1'b0;
    unique case (i_src)
      3'b001, 3'b010: o_p = i_x;
      3'b011:         o_p = i_x << 1;
      3'b100: begin
        o_p = ~(i_x << 1);
        o_c = 1'b1;
      end
      3'b101, 3'b110: begin
        o_p = ~i_x;
        o_c = 1'b1;
      end
      default: begin
        o_p = '0;
        o_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_041461_booth_mul_seq.sv
// Iterative radix-4 Booth multiply sequencer (mul/mulh/mulhsu/mulhu/mulw).
// One Booth step per cycle; an extra BUSY cycle at the end moves the finished
// accumulator into the registered result outputs.
module ysyx_041461_booth_mul_seq
  import ysyx_041461_mul_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  ysyx_041461_booth_mul_seq_if.slave   bus
);

  state_e           r_state, w_state_nxt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mulw;
  logic [XLEN-1:0]  r_res_hi, r_res_lo;

  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_p;
  logic             w_c;

  // Single shared partial-product generator, fed from the low scan window
  ysyx_041461_Booth_core u_booth (
    .i_src (r_y[2:0]),
    .i_x   (r_x),
    .o_p   (w_p),
    .o_c   (w_c)
  );

  // All steps retired once the counter reaches the op's step count
  assign w_last   = r_mulw ? (r_cnt == CNT_W'(STEPS_W)) : (r_cnt == CNT_W'(STEPS));
  assign w_accept = bus.mul_valid & bus.mul_ready;

  assign bus.mul_ready = (r_state == S_IDLE) & ~bus.flush & ~rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result_hi = r_res_hi;
  assign bus.result_lo = r_res_lo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: flush beats every normal transition
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (bus.flush)   w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.flush)                              w_state_nxt = S_IDLE;
        else if (bus.out_ready)                     w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, Booth accumulation and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_mulw   <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else if (w_accept) begin
      r_x    <= ext_x(bus.multiplicand, bus.mul_signed[1], bus.mulw);
      r_y    <= ext_y(bus.multiplier,   bus.mul_signed[0], bus.mulw);
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mulw <= bus.mulw;
    end else if (r_state == S_BUSY && !bus.flush) begin
      if (!w_last) begin
        r_acc <= r_acc + w_p + {{(PW-1){1'b0}}, w_c};
        r_x   <= r_x << 2;
        r_y   <= r_y >> 2;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_res_hi <= r_acc[PW-1:XLEN];
        r_res_lo <= r_mulw ? {{(XLEN-32){r_acc[31]}}, r_acc[31:0]} : r_acc[XLEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_041461_booth_mul_seq.sv
// Directed bench for the radix-4 Booth multiply sequencer.
module tb_ysyx_041461_booth_mul_seq;
  import ysyx_041461_mul_pkg::*;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  ysyx_041461_booth_mul_seq_if bus ();

  ysyx_041461_booth_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  s;
    logic        w;
    logic        chk_hi;
    logic [63:0] hi;
    logic [63:0] lo;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered just after a negedge; returns at a negedge with out_valid seen
  // (lat = cycles from accept edge) or lat = 0 on timeout.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                        input logic w, output int lat, output logic [63:0] hi,
                        output logic [63:0] lo);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.mul_signed   = s;
    bus.mulw         = w;
    bus.mul_valid    = 1'b1;
    @(posedge clk); #1;
    bus.mul_valid    = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    lat = 0; hi = '0; lo = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        hi  = bus.result_hi;
        lo  = bus.result_lo;
        break;
      end
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  // Starts an op and leaves it in BUSY after `cyc` step edges (at a negedge)
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input int cyc);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.mul_signed   = MUL_SS;
    bus.mulw         = 1'b0;
    bus.mul_valid    = 1'b1;
    @(posedge clk); #1;
    bus.mul_valid    = 1'b0;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
  endtask

  // out_valid must stay low for `cyc` cycles
  task automatic quiet(input string nm, input int cyc);
    int bad;
    bad = 0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk(nm, 64'(bad), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [63:0] hi, lo;

    vt[0] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFB, MUL_SS, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 34};
    vt[1] = '{64'd7, 64'd6, MUL_SS, 1'b0, 1'b1, 64'd0, 64'd42, 34};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_UU, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 34};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SU, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 34};
    vt[4] = '{64'h0000_0000_7FFF_FFFF, 64'd2, MUL_SS, 1'b1, 1'b0,
              64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 18};
    vt[5] = '{64'h8000_0000_0000_0000, 64'd2, MUL_UU, 1'b0, 1'b1, 64'd1, 64'd0, 34};
    vt[6] = '{64'h8000_0000_0000_0000, 64'd2, MUL_SS, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 34};
    vt[7] = '{64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFB, MUL_SS, 1'b1, 1'b0,
              64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 18};
    vt[8] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, MUL_UU, 1'b0, 1'b1,
              64'd1, 64'd0, 34};

    rst = 1'b1;
    bus.mul_valid = 1'b0; bus.mulw = 1'b0; bus.mul_signed = 2'b00;
    bus.multiplicand = '0; bus.multiplier = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  64'(bus.mul_ready), 64'd0);
    chk("rst_valid",  64'(bus.out_valid), 64'd0);
    chk("rst_hi",     bus.result_hi, 64'd0);
    chk("rst_lo",     bus.result_lo, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(bus.mul_ready), 64'd1);

    // Table of directed products
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].w, lat, hi, lo);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
      if (vt[i].chk_hi) chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
      take_result();
    end

    // Backpressure: hold result 5 cycles, ignore a stray request meanwhile
    run_op(64'd7, 64'd6, MUL_SS, 1'b0, lat, hi, lo);
    chk("bp_lo", lo, 64'd42);
    bus.mul_valid = 1'b1; bus.multiplicand = 64'd9; bus.multiplier = 64'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_ready", 64'(bus.mul_ready), 64'd0);
      chk("bp_hold",  bus.result_lo, 64'd42);
    end
    bus.mul_valid = 1'b0;
    take_result();
    chk("bp_back_idle", 64'(bus.mul_ready), 64'd1);
    chk("bp_drop",      64'(bus.out_valid), 64'd0);
    run_op(64'd5, 64'd5, MUL_SS, 1'b0, lat, hi, lo);
    chk("bp_next_lat", 64'(lat), 64'd34);
    chk("bp_next_lo",  lo, 64'd25);
    take_result();

    // Flush in BUSY
    start_op(64'd11, 64'd13, 10);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fl_idle",  64'(bus.mul_ready), 64'd1);
    quiet("fl_quiet", 40);

    // Reset in BUSY
    start_op(64'd11, 64'd13, 10);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rr_ready", 64'(bus.mul_ready), 64'd0);
    chk("rr_valid", 64'(bus.out_valid), 64'd0);
    chk("rr_lo",    bus.result_lo, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_idle",  64'(bus.mul_ready), 64'd1);
    quiet("rr_quiet", 40);

    // Flush with a request in IDLE: request must be dropped
    bus.flush = 1'b1; bus.mul_valid = 1'b1;
    bus.multiplicand = 64'd3; bus.multiplier = 64'd3; bus.mulw = 1'b0; bus.mul_signed = MUL_SS;
    #1;
    chk("fi_ready", 64'(bus.mul_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.mul_valid = 1'b0;
    quiet("fi_quiet", 40);
    chk("fi_idle", 64'(bus.mul_ready), 64'd1);

    // Flush in DONE drops the result
    run_op(64'd5, 64'd5, MUL_SS, 1'b0, lat, hi, lo);
    chk("fd_lo", lo, 64'd25);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fd_valid", 64'(bus.out_valid), 64'd0);
    chk("fd_idle",  64'(bus.mul_ready), 64'd1);

    // Clean op after all the kills
    run_op(64'd5, 64'd5, MUL_SS, 1'b0, lat, hi, lo);
    chk("post_lat", 64'(lat), 64'd34);
    chk("post_lo",  lo, 64'd25);
    chk("post_hi",  hi, 64'd0);
    take_result();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
